// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters (fetch, load/store)
// and the single-ported unified memory.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR  = 32,
   parameter int unsigned W_OPR = 32
);
   // instruction fetch port
   logic             if_req_i;
   logic [ADDR-1:0]  if_addr_i;
   logic             if_gnt_o;
   logic             if_rvalid_o;
   logic [W_OPR-1:0] if_rdata_o;

   // execute-stage load/store port
   logic             ls_req_i;
   logic             ls_write_i;
   logic [ADDR-1:0]  ls_addr_i;
   logic [W_OPR-1:0] ls_wdata_i;
   logic             ls_gnt_o;
   logic             ls_rvalid_o;
   logic [W_OPR-1:0] ls_rdata_o;
   logic             ls_stall_o;

   // memory command / return
   logic             mem_en_o;
   logic             mem_write_o;
   logic [ADDR-1:0]  mem_addr_o;
   logic [W_OPR-1:0] mem_wdata_o;
   logic [W_OPR-1:0] mem_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i,
      input  ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
      input  mem_rdata_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_stall_o,
      output mem_en_o, mem_write_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output ls_req_i, ls_write_i, ls_addr_i, ls_wdata_i,
      output mem_rdata_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_stall_o,
      input  mem_en_o, mem_write_o, mem_addr_o, mem_wdata_o
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store: one access in flight,
// load/store priority with a saturating starvation counter that eventually forces a fetch.
module mem_port_arbiter #(
   parameter int unsigned ADDR       = 32,
   parameter int unsigned W_OPR      = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned      CNT_W      = 4;
   localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LAT);
   localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   owner_t           r_owner, w_owner_nxt;
   logic             r_wr, w_wr_nxt;
   logic [CNT_W-1:0] r_starve, w_starve_nxt;

   logic             w_done;
   logic             w_arb;
   logic             w_if_force;
   logic             w_ls_gnt;
   logic             w_if_gnt;
   logic             w_if_rvalid;
   logic             w_ls_rvalid;
   logic [W_OPR-1:0] w_if_rdata;
   logic [W_OPR-1:0] w_ls_rdata;
   logic             w_mem_en;
   logic             w_mem_write;
   logic [ADDR-1:0]  w_mem_addr;
   logic [W_OPR-1:0] w_mem_wdata;
   logic             w_ls_stall;

   // Completion cycle doubles as an arbitration cycle so issue can be back-to-back.
   assign w_done     = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
   assign w_arb      = reset && ((r_state == S_IDLE) || w_done);
   assign w_if_force = bus.if_req_i && (r_starve == STARVE_TOP);
   assign w_ls_gnt   = w_arb && bus.ls_req_i && !w_if_force;
   assign w_if_gnt   = w_arb && bus.if_req_i && !w_ls_gnt;

   // Return path: only the recorded owner sees rvalid; stores return zero data.
   always_comb begin
      w_if_rvalid = 1'b0;
      w_ls_rvalid = 1'b0;
      w_if_rdata  = '0;
      w_ls_rdata  = '0;
      if (w_done) begin
         if (r_owner == OWN_LS) begin
            w_ls_rvalid = 1'b1;
            w_ls_rdata  = r_wr ? '0 : bus.mem_rdata_i;
         end else if (r_owner == OWN_IF) begin
            w_if_rvalid = 1'b1;
            w_if_rdata  = bus.mem_rdata_i;
         end
      end
   end

   // Memory command, driven straight from the winner in its grant cycle.
   always_comb begin
      w_mem_en    = 1'b0;
      w_mem_write = 1'b0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      if (w_ls_gnt) begin
         w_mem_en    = 1'b1;
         w_mem_write = bus.ls_write_i;
         w_mem_addr  = bus.ls_addr_i;
         w_mem_wdata = bus.ls_wdata_i;
      end else if (w_if_gnt) begin
         w_mem_en    = 1'b1;
         w_mem_addr  = bus.if_addr_i;
      end
   end

   // Next-state: transaction tracking and starvation counter.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_owner_nxt  = r_owner;
      w_wr_nxt     = r_wr;
      w_starve_nxt = r_starve;

      if (w_ls_gnt || w_if_gnt) begin
         w_state_nxt = S_WAIT;
         w_cnt_nxt   = LAT_INIT;
         w_owner_nxt = w_ls_gnt ? OWN_LS : OWN_IF;
         w_wr_nxt    = w_ls_gnt && bus.ls_write_i;
      end else if (w_done) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_owner_nxt = OWN_NONE;
         w_wr_nxt    = 1'b0;
      end else if (r_state == S_WAIT) begin
         w_cnt_nxt   = r_cnt - CNT_W'(1);
      end

      if (!bus.if_req_i || w_if_gnt) begin
         w_starve_nxt = '0;
      end else if (w_ls_gnt && (r_starve != STARVE_TOP)) begin
         w_starve_nxt = r_starve + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_owner  <= OWN_NONE;
         r_wr     <= 1'b0;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_owner  <= w_owner_nxt;
         r_wr     <= w_wr_nxt;
         r_starve <= w_starve_nxt;
      end
   end

   // An LS access counts as pending from its request through the grant cycle until rvalid.
   assign w_ls_stall = bus.ls_req_i ||
                       ((r_owner == OWN_LS) && (r_state == S_WAIT) && !w_ls_rvalid);

   assign bus.if_gnt_o    = w_if_gnt;
   assign bus.if_rvalid_o = w_if_rvalid;
   assign bus.if_rdata_o  = w_if_rdata;
   assign bus.ls_gnt_o    = w_ls_gnt;
   assign bus.ls_rvalid_o = w_ls_rvalid;
   assign bus.ls_rdata_o  = w_ls_rdata;
   assign bus.ls_stall_o  = w_ls_stall;
   assign bus.mem_en_o    = w_mem_en;
   assign bus.mem_write_o = w_mem_write;
   assign bus.mem_addr_o  = w_mem_addr;
   assign bus.mem_wdata_o = w_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model plus a scoreboard of expected returns,
// directed scenarios on a MEM_LAT=2 instance and back-to-back fetch on a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
   localparam int unsigned ADDR  = 32;
   localparam int unsigned W_OPR = 32;
   localparam int          LAT   = 2;
   localparam int          SMAX  = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter_if #(.ADDR(ADDR), .W_OPR(W_OPR)) u_bus  ();
   mem_port_arbiter_if #(.ADDR(ADDR), .W_OPR(W_OPR)) u_bus1 ();

   mem_port_arbiter #(.ADDR(ADDR), .W_OPR(W_OPR), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
      .clk(clk), .reset(reset), .bus(u_bus));
   mem_port_arbiter #(.ADDR(ADDR), .W_OPR(W_OPR), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
      .clk(clk), .reset(reset), .bus(u_bus1));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] base_rd(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // Memory model: data is only valid in the exact return cycle, garbage otherwise.
   logic [31:0] mem_arr [0:255];
   bit          mem_ready = 1'b0;
   int          rd_stamp  = -100;
   int          rd_stamp1 = -100;
   logic [31:0] rd_val, rd_val1;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem_arr[a[9:2]];
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= base_rd(32'(i) * 32'd4);
         mem_arr[16] <= 32'hDEAD_BEEF;
         mem_ready   <= 1'b1;
      end else if (u_bus.mem_en_o) begin
         if (u_bus.mem_write_o) mem_arr[u_bus.mem_addr_o[9:2]] <= u_bus.mem_wdata_o;
         else begin
            rd_stamp <= cyc;
            rd_val   <= mem_rd(u_bus.mem_addr_o);
         end
      end
      if (u_bus1.mem_en_o && !u_bus1.mem_write_o) begin
         rd_stamp1 <= cyc;
         rd_val1   <= base_rd(u_bus1.mem_addr_o);
      end
   end

   assign u_bus.mem_rdata_i  = (cyc == rd_stamp + LAT) ? rd_val  : 32'hBAD0_BAD0;
   assign u_bus1.mem_rdata_i = (cyc == rd_stamp1 + 1)  ? rd_val1 : 32'hBAD0_BAD0;

   // Scoreboard: grants push the expected return, rvalids pop and compare.
   typedef struct { int due; logic [31:0] data; } exp_t;
   exp_t q_if[$];
   exp_t q_ls[$];
   bit   gnt_log[$];
   bit   mon_en = 1'b0;

   always @(negedge clk) begin
      if (reset && mon_en) begin
         check("ls_stall", 64'(u_bus.ls_stall_o),
               64'(u_bus.ls_req_i | ((q_ls.size() != 0) & !u_bus.ls_rvalid_o)));
         check("dual_gnt", 64'(u_bus.if_gnt_o & u_bus.ls_gnt_o), 64'(0));
         check("mem_en", 64'(u_bus.mem_en_o), 64'(u_bus.if_gnt_o | u_bus.ls_gnt_o));

         if (u_bus.ls_rvalid_o) begin
            if (q_ls.size() == 0) check("ls_rv_unexp", 64'(u_bus.ls_rvalid_o), 64'(0));
            else begin
               check("ls_rv_cycle", 64'(cyc), 64'(q_ls[0].due));
               check("ls_rdata", 64'(u_bus.ls_rdata_o), 64'(q_ls[0].data));
               q_ls.delete(0);
            end
         end else begin
            check("ls_rdata_idle", 64'(u_bus.ls_rdata_o), 64'(0));
            if (q_ls.size() != 0 && q_ls[0].due <= cyc) begin
               check("ls_rv_missing", 64'(u_bus.ls_rvalid_o), 64'(1));
               q_ls.delete(0);
            end
         end

         if (u_bus.if_rvalid_o) begin
            if (q_if.size() == 0) check("if_rv_unexp", 64'(u_bus.if_rvalid_o), 64'(0));
            else begin
               check("if_rv_cycle", 64'(cyc), 64'(q_if[0].due));
               check("if_rdata", 64'(u_bus.if_rdata_o), 64'(q_if[0].data));
               q_if.delete(0);
            end
         end else begin
            check("if_rdata_idle", 64'(u_bus.if_rdata_o), 64'(0));
            if (q_if.size() != 0 && q_if[0].due <= cyc) begin
               check("if_rv_missing", 64'(u_bus.if_rvalid_o), 64'(1));
               q_if.delete(0);
            end
         end

         if (u_bus.ls_gnt_o) begin
            check("ls_mem_addr", 64'(u_bus.mem_addr_o), 64'(u_bus.ls_addr_i));
            check("ls_mem_write", 64'(u_bus.mem_write_o), 64'(u_bus.ls_write_i));
            check("ls_mem_wdata", 64'(u_bus.mem_wdata_o), 64'(u_bus.ls_wdata_i));
            q_ls.push_back('{due: cyc + LAT,
                             data: u_bus.ls_write_i ? 32'h0 : mem_rd(u_bus.ls_addr_i)});
            gnt_log.push_back(1'b1);
         end else if (u_bus.if_gnt_o) begin
            check("if_mem_addr", 64'(u_bus.mem_addr_o), 64'(u_bus.if_addr_i));
            check("if_mem_write", 64'(u_bus.mem_write_o), 64'(0));
            check("if_mem_wdata", 64'(u_bus.mem_wdata_o), 64'(0));
            q_if.push_back('{due: cyc + LAT, data: mem_rd(u_bus.if_addr_i)});
            gnt_log.push_back(1'b0);
         end else begin
            check("idle_mem_addr", 64'(u_bus.mem_addr_o), 64'(0));
            check("idle_mem_wdata", 64'(u_bus.mem_wdata_o), 64'(0));
         end
      end
   end

   task automatic wait_ls_gnt(output int gcyc);
      gcyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_bus.ls_gnt_o) begin
            gcyc = cyc;
            return;
         end
      end
      check("ls_gnt_timeout", 64'(u_bus.ls_gnt_o), 64'(1));
   endtask

   task automatic wait_if_gnt(output int gcyc);
      gcyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_bus.if_gnt_o) begin
            gcyc = cyc;
            return;
         end
      end
      check("if_gnt_timeout", 64'(u_bus.if_gnt_o), 64'(1));
   endtask

   task automatic ls_op(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
      int g;
      @(posedge clk); #1;
      u_bus.ls_req_i   = 1'b1;
      u_bus.ls_write_i = wr;
      u_bus.ls_addr_i  = a;
      u_bus.ls_wdata_i = d;
      wait_ls_gnt(g);
      @(posedge clk); #1;
      u_bus.ls_req_i = 1'b0;
      rd  = '0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (u_bus.ls_rvalid_o) begin
            rd  = u_bus.ls_rdata_o;
            lat = cyc - g;
            return;
         end
      end
      check("ls_rv_timeout", 64'(u_bus.ls_rvalid_o), 64'(1));
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  exp_ord;
      int          lat, g0, g1;
      bit          gl, gi;

      reset = 1'b0;
      u_bus.if_req_i  = 1'b0;  u_bus.if_addr_i  = '0;
      u_bus.ls_req_i  = 1'b0;  u_bus.ls_write_i = 1'b0;
      u_bus.ls_addr_i = '0;    u_bus.ls_wdata_i = '0;
      u_bus1.if_req_i  = 1'b0; u_bus1.if_addr_i  = '0;
      u_bus1.ls_req_i  = 1'b0; u_bus1.ls_write_i = 1'b0;
      u_bus1.ls_addr_i = '0;   u_bus1.ls_wdata_i = '0;

      // reset state: outputs quiet, stall follows ls_req_i
      #2;
      check("rst_mem_en", 64'(u_bus.mem_en_o), 64'(0));
      check("rst_if_gnt", 64'(u_bus.if_gnt_o), 64'(0));
      check("rst_stall0", 64'(u_bus.ls_stall_o), 64'(0));
      u_bus.ls_req_i = 1'b1;
      u_bus.if_req_i = 1'b1;
      #1;
      check("rst_stall1", 64'(u_bus.ls_stall_o), 64'(1));
      check("rst_ls_gnt", 64'(u_bus.ls_gnt_o), 64'(0));
      check("rst_if_gnt_req", 64'(u_bus.if_gnt_o), 64'(0));
      check("rst_mem_en_req", 64'(u_bus.mem_en_o), 64'(0));
      u_bus.ls_req_i = 1'b0;
      u_bus.if_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      // lone load of 0x40
      @(posedge clk); #1;
      u_bus.ls_req_i  = 1'b1;
      u_bus.ls_addr_i = 32'h40;
      wait_ls_gnt(g0);
      check("ld_mem_en_t0", 64'(u_bus.mem_en_o), 64'(1));
      check("ld_mem_addr_t0", 64'(u_bus.mem_addr_o), 64'h40);
      check("ld_stall_t0", 64'(u_bus.ls_stall_o), 64'(1));
      @(posedge clk); #1;
      u_bus.ls_req_i = 1'b0;
      @(negedge clk);
      check("ld_stall_t1", 64'(u_bus.ls_stall_o), 64'(1));
      check("ld_rvalid_t1", 64'(u_bus.ls_rvalid_o), 64'(0));
      @(negedge clk);
      check("ld_rvalid_t2", 64'(u_bus.ls_rvalid_o), 64'(1));
      check("ld_rdata_t2", 64'(u_bus.ls_rdata_o), 64'hDEAD_BEEF);
      check("ld_stall_t2", 64'(u_bus.ls_stall_o), 64'(0));

      // store then read back
      ls_op(1'b1, 32'h80, 32'h1234, rd, lat);
      check("st_latency", 64'(lat), 64'(LAT));
      check("st_rdata", 64'(rd), 64'(0));
      ls_op(1'b0, 32'h80, 32'h0, rd, lat);
      check("st_readback", 64'(rd), 64'h1234);

      // both requesting continuously: LS,LS,LS,IF repeating
      @(posedge clk); #1;
      gnt_log.delete();
      u_bus.if_req_i   = 1'b1;
      u_bus.if_addr_i  = 32'h100;
      u_bus.ls_req_i   = 1'b1;
      u_bus.ls_write_i = 1'b0;
      u_bus.ls_addr_i  = 32'h200;
      for (int i = 0; i < 40 && gnt_log.size() < 8; i++) @(negedge clk);
      @(posedge clk); #1;
      u_bus.if_req_i = 1'b0;
      u_bus.ls_req_i = 1'b0;
      repeat (4) @(negedge clk);
      check("starve_gnt_count", 64'(gnt_log.size() >= 8), 64'(1));
      exp_ord = 8'b1110_1110;
      for (int i = 0; i < 8 && i < gnt_log.size(); i++)
         check($sformatf("starve_order%0d", i), 64'(gnt_log[i]), 64'(exp_ord[7-i]));

      // back-to-back fetches 0x0, 0x4
      @(posedge clk); #1;
      u_bus.if_req_i  = 1'b1;
      u_bus.if_addr_i = 32'h0;
      wait_if_gnt(g0);
      @(posedge clk); #1;
      u_bus.if_addr_i = 32'h4;
      wait_if_gnt(g1);
      check("b2b_gap", 64'(g1 - g0), 64'(LAT));
      check("b2b_rv_with_gnt", 64'(u_bus.if_rvalid_o), 64'(1));
      @(posedge clk); #1;
      u_bus.if_req_i = 1'b0;
      repeat (3) @(negedge clk);

      // reset asserted the cycle after an LS grant
      @(posedge clk); #1;
      u_bus.ls_req_i   = 1'b1;
      u_bus.ls_write_i = 1'b0;
      u_bus.ls_addr_i  = 32'h300;
      wait_ls_gnt(g0);
      @(posedge clk); #1;
      u_bus.ls_req_i = 1'b0;
      reset  = 1'b0;
      mon_en = 1'b0;
      q_ls.delete();
      q_if.delete();
      #1;
      check("mid_rst_ls_rvalid", 64'(u_bus.ls_rvalid_o), 64'(0));
      check("mid_rst_mem_en", 64'(u_bus.mem_en_o), 64'(0));
      check("mid_rst_mem_addr", 64'(u_bus.mem_addr_o), 64'(0));
      check("mid_rst_stall", 64'(u_bus.ls_stall_o), 64'(0));
      check("mid_rst_ls_rdata", 64'(u_bus.ls_rdata_o), 64'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mid_rst_no_rv", 64'(u_bus.ls_rvalid_o), 64'(0));
      end
      @(posedge clk); #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      ls_op(1'b0, 32'h44, 32'h0, rd, lat);
      check("post_rst_latency", 64'(lat), 64'(LAT));
      check("post_rst_rdata", 64'(rd), 64'(base_rd(32'h44)));

      // random mixed traffic, held until granted, checked by the scoreboard
      for (int n = 0; n < 80; n++) begin
         @(negedge clk);
         gl = u_bus.ls_gnt_o;
         gi = u_bus.if_gnt_o;
         @(posedge clk); #1;
         if (!u_bus.ls_req_i || gl) begin
            u_bus.ls_req_i   = 1'($urandom_range(0, 1));
            u_bus.ls_write_i = 1'($urandom_range(0, 1));
            u_bus.ls_addr_i  = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
            u_bus.ls_wdata_i = $urandom;
         end
         if (!u_bus.if_req_i || gi) begin
            u_bus.if_req_i  = 1'($urandom_range(0, 1));
            u_bus.if_addr_i = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
         end
      end
      @(negedge clk);
      @(posedge clk); #1;
      u_bus.ls_req_i = 1'b0;
      u_bus.if_req_i = 1'b0;
      repeat (6) @(negedge clk);
      check("drain_ls", 64'(q_ls.size()), 64'(0));
      check("drain_if", 64'(q_if.size()), 64'(0));

      // MEM_LAT=1 instance: a fetch every cycle, data one cycle behind
      @(posedge clk); #1;
      u_bus1.if_req_i  = 1'b1;
      u_bus1.if_addr_i = 32'h0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("l1_if_gnt", 64'(u_bus1.if_gnt_o), 64'(1));
         check("l1_mem_addr", 64'(u_bus1.mem_addr_o), 64'(32'(k) * 32'd4));
         if (k == 0) check("l1_rv_first", 64'(u_bus1.if_rvalid_o), 64'(0));
         else begin
            check("l1_rvalid", 64'(u_bus1.if_rvalid_o), 64'(1));
            check("l1_rdata", 64'(u_bus1.if_rdata_o), 64'(base_rd(32'(k - 1) * 32'd4)));
         end
         @(posedge clk); #1;
         u_bus1.if_addr_i = 32'(k + 1) * 32'd4;
      end
      u_bus1.if_req_i = 1'b0;
      @(negedge clk);
      check("l1_rv_last", 64'(u_bus1.if_rvalid_o), 64'(1));
      check("l1_rdata_last", 64'(u_bus1.if_rdata_o), 64'(base_rd(32'd20)));
      check("l1_gnt_stop", 64'(u_bus1.if_gnt_o), 64'(0));
      @(negedge clk);
      check("l1_rv_quiet", 64'(u_bus1.if_rvalid_o), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d, expected summary before it", cyc);
      $fatal(1);
   end
endmodule
